pipeline_hazard_unit: RTL and testbench
=======================================

Name: pipeline_hazard_unit

Overview:
Parametrised successor to the pipeline control logic of the 5-stage RISC-V core. It combines:
- EX-stage operand forwarding selects.
- Load-use stall and branch/JAL/JALR redirect with per-stage enable/flush.
- A sequential MMIO wait-state FSM that freezes the whole pipeline while a slow I/O access (LED/PS2/VGA/num_buf region) sits in EX/MEM.

It sits beside data_path and drives every pipeline-register enable/flush and the PC mux.

Parameters:
REG_AW, 5, register-index width
MMIO_WAIT, 2, freeze cycles per MMIO access in EX/MEM (0 = no freeze)
WAIT_CW, 4, wait-counter width; must satisfy 2^WAIT_CW > MMIO_WAIT
CNT_W, 16, performance-counter width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
if_id_rs1, if_id_rs2  in  REG_AW  source registers in ID
id_ex_rs1, id_ex_rs2  in  REG_AW  source registers in EX
id_ex_rd  in  REG_AW  destination in EX
id_ex_mem_read  in  1  EX holds a load
ex_mem_rd  in  REG_AW  destination in MEM
ex_mem_reg_write  in  1  MEM writes the register file
ex_mem_mmio  in  1  MEM access decodes to the MMIO region
mem_wb_rd  in  REG_AW  destination in WB
mem_wb_reg_write  in  1  WB writes the register file
branch_taken  in  1  conditional branch in EX resolved taken
jal  in  1  JAL in EX
jalr  in  1  JALR in EX
fwd_a, fwd_b  out  2  operand select: 00 = regfile, 10 = EX/MEM, 01 = MEM/WB
pc_sel  out  2  00 = PC+4, 01 = branch target, 10 = JAL target, 11 = JALR target
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  pipeline-register enables
if_id_flush, id_ex_flush  out  1  insert bubble (takes effect only when the matching enable is 1)
perf_stall, perf_flush, perf_mmio  out  CNT_W  performance counters (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - FSM returns to RUN, wait counter = 0, perf counters = 0.
  - While rst is high, all enables = 0, both flushes = 1, pc_sel = 00, fwd_a = fwd_b = 00.
- Forwarding (combinational, per operand):
  - EX/MEM match (reg_write, rd != 0, rd == id_ex_rsN) gives 10.
  - Otherwise a MEM/WB match gives 01.
  - Otherwise 00. EX/MEM has priority when both match.
- FSM states:
  - RUN: if ex_mem_mmio=1 and MMIO_WAIT > 0, assert freeze this cycle, go to WAIT, counter = 1.
  - WAIT: freeze = 1 while counter < MMIO_WAIT, counter increments each cycle. In the cycle counter == MMIO_WAIT, freeze = 0, go to RUN, counter = 0. The pipeline advances that cycle, so the same access never re-triggers.
  - Total freeze per MMIO access = exactly MMIO_WAIT cycles.
- Priority, highest first: freeze > redirect > load-use > normal.
  - freeze: all five enables = 0, flushes = 0, pc_sel = 00. Any redirect or load-use condition is ignored; it is re-evaluated after release because ID/EX is held.
  - redirect (jalr, else jal, else branch_taken): pc_sel = 11/10/01 respectively; if_id_flush = 1, id_ex_flush = 1; all enables = 1. If more than one of jalr/jal/branch_taken is asserted, jalr > jal > branch.
  - load-use: id_ex_mem_read, id_ex_rd != 0, and id_ex_rd equals if_id_rs1 or if_id_rs2. Outputs: pc_en = 0, if_id_en = 0, id_ex_flush = 1, remaining enables = 1. Exactly one bubble cycle.
  - normal: all enables = 1, flushes = 0, pc_sel = 00.
- Reset mid-WAIT aborts the wait immediately; the next access after reset restarts a full MMIO_WAIT count.
- rd or rs == x0 never matches for forwarding or load-use.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: three saturating counters, each capped at 2^CNT_W-1:
  - perf_stall increments on every load-use cycle.
  - perf_flush increments on every redirect cycle.
  - perf_mmio increments on every freeze cycle.
- Undefined: the counters are not built; the perf_* outputs are tied to 0.

Decomposition:
- Shared package pipeline_pkg holds:
  - PC_SEL_SEQ/BR/JAL/JALR codes
  - FWD_RF/EXMEM/MEMWB codes
  - FSM state encoding (ST_RUN, ST_WAIT)
- One sub-module, forwarding_unit, instantiated once per operand, computes the 2-bit select from rs and the two downstream rd/reg_write pairs.
- FSM, priority mux and perf counters stay in the top.

Test Plan:
- Forwarding: ex_mem_rd = 5, ex_mem_reg_write = 1, mem_wb_rd = 5, mem_wb_reg_write = 1, id_ex_rs1 = 5 -> fwd_a = 10. Drop ex_mem_reg_write -> fwd_a = 01. With rd = 0 -> fwd_a = 00.
- Load-use: id_ex_mem_read = 1, id_ex_rd = 3, if_id_rs2 = 3 -> one cycle with pc_en = 0, if_id_en = 0, id_ex_flush = 1. With id_ex_rd = 0 -> no stall.
- Redirect: jalr = 1 and branch_taken = 1 together -> pc_sel = 11, if_id_flush = 1, id_ex_flush = 1 for 1 cycle. branch_taken alone -> pc_sel = 01.
- MMIO freeze, MMIO_WAIT = 2: ex_mem_mmio held -> all enables 0 for exactly 2 cycles, then 1; next MMIO access freezes again for 2 cycles. With MMIO_WAIT = 0 -> never freezes.
- Freeze plus redirect: branch_taken = 1 during the freeze -> pc_sel = 00 and flushes = 0 until release, then pc_sel = 01 on the release cycle.
- Reset: rst pulsed mid-WAIT -> outputs take reset values asynchronously and the FSM is in RUN. With PIPE_PERF_CNT_EN defined, counters read 0 after reset and perf_mmio = 2 after one MMIO access.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard unit: PC-mux selects, forwarding
// selects, wait-state FSM states and the resolved per-cycle hazard action.
package pipeline_pkg;

    localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
    localparam logic [1:0] PC_SEL_BR   = 2'b01;
    localparam logic [1:0] PC_SEL_JAL  = 2'b10;
    localparam logic [1:0] PC_SEL_JALR = 2'b11;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } fsm_state_e;

    typedef enum logic [1:0] {
        ACT_NORMAL,
        ACT_LOAD_USE,
        ACT_REDIRECT,
        ACT_FREEZE
    } hazard_act_e;

endpackage

// File: rtl/pipeline_hazard_unit_forwarding_unit.sv
// Operand forwarding select for one EX-stage source register; the younger
// EX/MEM result wins over MEM/WB, and x0 is never forwarded.
module forwarding_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_reg_write,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              mem_wb_reg_write,
    output logic [1:0]        fwd
);

    logic ex_mem_hit;
    logic mem_wb_hit;

    assign ex_mem_hit = ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == rs);
    assign mem_wb_hit = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == rs);

    always_comb begin
        // NOTE: assign a default before any branch so no latch can be inferred.
        fwd = FWD_RF;
        if (ex_mem_hit) begin
            fwd = FWD_EXMEM;
        end else if (mem_wb_hit) begin
            fwd = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Pipeline control for the 5-stage core: forwarding, load-use stall, redirect
// and MMIO wait-state freeze. Optional perf counters under PIPE_PERF_CNT_EN.
module pipeline_hazard_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned MMIO_WAIT = 2,
    parameter int unsigned WAIT_CW   = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] if_id_rs1,
    input  logic [REG_AW-1:0] if_id_rs2,
    input  logic [REG_AW-1:0] id_ex_rs1,
    input  logic [REG_AW-1:0] id_ex_rs2,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_mem_read,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_reg_write,
    input  logic              ex_mem_mmio,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              mem_wb_reg_write,
    input  logic              branch_taken,
    input  logic              jal,
    input  logic              jalr,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        pc_sel,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic [CNT_W-1:0]  perf_stall,
    output logic [CNT_W-1:0]  perf_flush,
    output logic [CNT_W-1:0]  perf_mmio
);

    localparam logic [WAIT_CW-1:0] WAIT_LAST = WAIT_CW'(MMIO_WAIT);

    logic [1:0]         fwd_a_raw;
    logic [1:0]         fwd_b_raw;
    fsm_state_e         state;
    logic [WAIT_CW-1:0] wait_cnt;
    logic               freeze;
    logic               redirect;
    logic               load_use;
    hazard_act_e        act;

    forwarding_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .rs               (id_ex_rs1),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_reg_write (ex_mem_reg_write),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_reg_write (mem_wb_reg_write),
        .fwd              (fwd_a_raw)
    );

    forwarding_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .rs               (id_ex_rs2),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_reg_write (ex_mem_reg_write),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_reg_write (mem_wb_reg_write),
        .fwd              (fwd_b_raw)
    );

    assign fwd_a = rst ? FWD_RF : fwd_a_raw;
    assign fwd_b = rst ? FWD_RF : fwd_b_raw;

    // Freeze starts in the same cycle the access reaches EX/MEM; the release
    // cycle lets the pipeline advance so that access cannot re-trigger.
    always_comb begin
        freeze = 1'b0;
        if (MMIO_WAIT > 0) begin
            case (state)
                ST_RUN:  freeze = ex_mem_mmio;
                ST_WAIT: freeze = (wait_cnt < WAIT_LAST);
                default: freeze = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if ((MMIO_WAIT > 0) && ex_mem_mmio) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt >= WAIT_LAST) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CW'(1);
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign redirect = jalr || jal || branch_taken;
    assign load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                      ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

    always_comb begin
        if (freeze) begin
            act = ACT_FREEZE;
        end else if (redirect) begin
            act = ACT_REDIRECT;
        end else if (load_use) begin
            act = ACT_LOAD_USE;
        end else begin
            act = ACT_NORMAL;
        end
    end

    always_comb begin
        pc_sel      = PC_SEL_SEQ;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (rst) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (act)
                ACT_FREEZE: begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
                end
                ACT_REDIRECT: begin
                    if (jalr) begin
                        pc_sel = PC_SEL_JALR;
                    end else if (jal) begin
                        pc_sel = PC_SEL_JAL;
                    end else begin
                        pc_sel = PC_SEL_BR;
                    end
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                ACT_LOAD_USE: begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] mmio_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
            mmio_q  <= '0;
        end else begin
            if ((act == ACT_LOAD_USE) && (stall_q != CNT_MAX)) stall_q <= stall_q + CNT_W'(1);
            if ((act == ACT_REDIRECT) && (flush_q != CNT_MAX)) flush_q <= flush_q + CNT_W'(1);
            if ((act == ACT_FREEZE)   && (mmio_q  != CNT_MAX)) mmio_q  <= mmio_q  + CNT_W'(1);
        end
    end

    assign perf_stall = stall_q;
    assign perf_flush = flush_q;
    assign perf_mmio  = mmio_q;
`else
    assign perf_stall = '0;
    assign perf_flush = '0;
    assign perf_mmio  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: MMIO_WAIT=2 instance plus an
// MMIO_WAIT=0 instance sharing the same stimulus.
module tb_pipeline_hazard_unit;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [4:0] if_id_rs1, if_id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic       id_ex_mem_read;
    logic [4:0] ex_mem_rd;
    logic       ex_mem_reg_write, ex_mem_mmio;
    logic [4:0] mem_wb_rd;
    logic       mem_wb_reg_write;
    logic       branch_taken, jal, jalr;

    logic [1:0]  fwd_a, fwd_b, pc_sel;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush;
    logic [15:0] perf_stall, perf_flush, perf_mmio;

    logic [1:0]  fwd_a0, fwd_b0, pc_sel0;
    logic        pc_en0, if_id_en0, id_ex_en0, ex_mem_en0, mem_wb_en0;
    logic        if_id_flush0, id_ex_flush0;
    logic [15:0] perf_stall0, perf_flush0, perf_mmio0;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    pipeline_hazard_unit #(.REG_AW(5), .MMIO_WAIT(2), .WAIT_CW(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_mem_read(id_ex_mem_read),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mmio(ex_mem_mmio),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
        .branch_taken(branch_taken), .jal(jal), .jalr(jalr),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_sel(pc_sel),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_mmio(perf_mmio)
    );

    pipeline_hazard_unit #(.REG_AW(5), .MMIO_WAIT(0), .WAIT_CW(4), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst),
        .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_mem_read(id_ex_mem_read),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mmio(ex_mem_mmio),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
        .branch_taken(branch_taken), .jal(jal), .jalr(jalr),
        .fwd_a(fwd_a0), .fwd_b(fwd_b0), .pc_sel(pc_sel0),
        .pc_en(pc_en0), .if_id_en(if_id_en0), .id_ex_en(id_ex_en0),
        .ex_mem_en(ex_mem_en0), .mem_wb_en(mem_wb_en0),
        .if_id_flush(if_id_flush0), .id_ex_flush(id_ex_flush0),
        .perf_stall(perf_stall0), .perf_flush(perf_flush0), .perf_mmio(perf_mmio0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Enable vector order: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}
    task automatic chk_ctrl(input string tag, input logic [1:0] e_sel, input logic [4:0] e_en,
                            input logic e_iff, input logic e_ief);
        check({tag, ".pc_sel"},      32'(pc_sel), 32'(e_sel));
        check({tag, ".en"},          32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(e_en));
        check({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(e_iff));
        check({tag, ".id_ex_flush"}, 32'(id_ex_flush), 32'(e_ief));
    endtask

    task automatic chk_ctrl0(input string tag, input logic [1:0] e_sel, input logic [4:0] e_en);
        check({tag, ".w0.pc_sel"}, 32'(pc_sel0), 32'(e_sel));
        check({tag, ".w0.en"},     32'({pc_en0, if_id_en0, id_ex_en0, ex_mem_en0, mem_wb_en0}), 32'(e_en));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        if_id_rs1 = '0; if_id_rs2 = '0; id_ex_rs1 = '0; id_ex_rs2 = '0; id_ex_rd = '0;
        id_ex_mem_read = 1'b0;
        ex_mem_rd = '0; ex_mem_reg_write = 1'b0; ex_mem_mmio = 1'b0;
        mem_wb_rd = '0; mem_wb_reg_write = 1'b0;
        branch_taken = 1'b0; jal = 1'b0; jalr = 1'b0;
    endtask

    initial begin
        // Reset: outputs forced even with a forwarding match present
        idle_inputs();
        rst = 1'b1;
        ex_mem_rd = 5'd5; ex_mem_reg_write = 1'b1; id_ex_rs1 = 5'd5;
        #1;
        chk_ctrl("reset", 2'b00, 5'b00000, 1'b1, 1'b1);
        check("reset.fwd_a", 32'(fwd_a), 32'(2'b00));
        check("reset.fwd_b", 32'(fwd_b), 32'(2'b00));
        check("reset.perf_stall", 32'(perf_stall), 32'd0);
        check("reset.perf_mmio",  32'(perf_mmio),  32'd0);
        @(posedge clk);
        tick();
        rst = 1'b0;
        idle_inputs();
        #1;
        chk_ctrl("normal", 2'b00, 5'b11111, 1'b0, 1'b0);

        // Forwarding
        tick();
        ex_mem_rd = 5'd5; ex_mem_reg_write = 1'b1;
        mem_wb_rd = 5'd5; mem_wb_reg_write = 1'b1;
        id_ex_rs1 = 5'd5; id_ex_rs2 = 5'd0;
        #1;
        check("fwd.both_match.a", 32'(fwd_a), 32'(2'b10));
        check("fwd.rs2_x0.b",     32'(fwd_b), 32'(2'b00));
        ex_mem_reg_write = 1'b0;
        #1;
        check("fwd.memwb_only.a", 32'(fwd_a), 32'(2'b01));
        ex_mem_reg_write = 1'b1; ex_mem_rd = 5'd0; mem_wb_rd = 5'd0; id_ex_rs1 = 5'd0;
        #1;
        check("fwd.rd_x0.a", 32'(fwd_a), 32'(2'b00));
        ex_mem_rd = 5'd7; mem_wb_rd = 5'd9; id_ex_rs2 = 5'd9; id_ex_rs1 = 5'd7;
        #1;
        check("fwd.split.a", 32'(fwd_a), 32'(2'b10));
        check("fwd.split.b", 32'(fwd_b), 32'(2'b01));
        chk_ctrl("fwd.ctrl", 2'b00, 5'b11111, 1'b0, 1'b0);

        // Load-use: one bubble cycle, then normal
        tick();
        idle_inputs();
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd3; if_id_rs2 = 5'd3;
        #1;
        chk_ctrl("load_use", 2'b00, 5'b00111, 1'b0, 1'b1);
        tick();
        id_ex_mem_read = 1'b0;
        #1;
        chk_ctrl("load_use.after", 2'b00, 5'b11111, 1'b0, 1'b0);
        tick();
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd0; if_id_rs1 = 5'd0; if_id_rs2 = 5'd0;
        #1;
        chk_ctrl("load_use.rd_x0", 2'b00, 5'b11111, 1'b0, 1'b0);

        // Redirect priorities
        tick();
        idle_inputs();
        jalr = 1'b1; branch_taken = 1'b1;
        #1;
        chk_ctrl("redir.jalr_br", 2'b11, 5'b11111, 1'b1, 1'b1);
        tick();
        jalr = 1'b0;
        #1;
        chk_ctrl("redir.br", 2'b01, 5'b11111, 1'b1, 1'b1);
        tick();
        branch_taken = 1'b0; jal = 1'b1;
        #1;
        chk_ctrl("redir.jal", 2'b10, 5'b11111, 1'b1, 1'b1);
        tick();
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd3; if_id_rs1 = 5'd3;
        #1;
        chk_ctrl("redir.over_load_use", 2'b10, 5'b11111, 1'b1, 1'b1);
        tick();
        idle_inputs();
        #1;
        chk_ctrl("redir.after", 2'b00, 5'b11111, 1'b0, 1'b0);

        // MMIO freeze: held access gives 2 frozen, 1 release, 2 frozen ...
        ex_mem_mmio = 1'b1;
        #1;
        chk_ctrl("mmio.c0", 2'b00, 5'b00000, 1'b0, 1'b0);
        chk_ctrl0("mmio.c0", 2'b00, 5'b11111);
        tick();
        #1;
        chk_ctrl("mmio.c1", 2'b00, 5'b00000, 1'b0, 1'b0);
        chk_ctrl0("mmio.c1", 2'b00, 5'b11111);
        tick();
        #1;
        chk_ctrl("mmio.release", 2'b00, 5'b11111, 1'b0, 1'b0);
        tick();
        #1;
        chk_ctrl("mmio2.c0", 2'b00, 5'b00000, 1'b0, 1'b0);
        tick();
        ex_mem_mmio = 1'b0;
        #1;
        chk_ctrl("mmio2.c1", 2'b00, 5'b00000, 1'b0, 1'b0);
        tick();
        #1;
        chk_ctrl("mmio2.release", 2'b00, 5'b11111, 1'b0, 1'b0);
        tick();
        #1;
        chk_ctrl("mmio2.idle", 2'b00, 5'b11111, 1'b0, 1'b0);

        // Freeze masks a branch until the release cycle
        ex_mem_mmio = 1'b1; branch_taken = 1'b1;
        #1;
        chk_ctrl("frz_br.c0", 2'b00, 5'b00000, 1'b0, 1'b0);
        chk_ctrl0("frz_br.c0", 2'b01, 5'b11111);
        tick();
        ex_mem_mmio = 1'b0;
        #1;
        chk_ctrl("frz_br.c1", 2'b00, 5'b00000, 1'b0, 1'b0);
        tick();
        #1;
        chk_ctrl("frz_br.release", 2'b01, 5'b11111, 1'b1, 1'b1);
        tick();
        branch_taken = 1'b0;
        #1;
        // 1 load-use, 4+1 redirect, 4+2 freeze cycles so far
        check("perf.stall_total", 32'(perf_stall), PERF_ON ? 32'd1 : 32'd0);
        check("perf.flush_total", 32'(perf_flush), PERF_ON ? 32'd5 : 32'd0);
        check("perf.mmio_total",  32'(perf_mmio),  PERF_ON ? 32'd6 : 32'd0);
        check("perf.mmio_w0",     32'(perf_mmio0), 32'd0);

        // Reset in the middle of WAIT
        ex_mem_mmio = 1'b1;
        #1;
        chk_ctrl("rstwait.c0", 2'b00, 5'b00000, 1'b0, 1'b0);
        tick();
        ex_mem_mmio = 1'b0;
        #1;
        chk_ctrl("rstwait.c1", 2'b00, 5'b00000, 1'b0, 1'b0);
        ex_mem_rd = 5'd4; ex_mem_reg_write = 1'b1; id_ex_rs2 = 5'd4;
        rst = 1'b1;
        #1;
        chk_ctrl("rstwait.rst", 2'b00, 5'b00000, 1'b1, 1'b1);
        check("rstwait.fwd_b", 32'(fwd_b), 32'(2'b00));
        check("rstwait.perf_stall", 32'(perf_stall), 32'd0);
        check("rstwait.perf_flush", 32'(perf_flush), 32'd0);
        check("rstwait.perf_mmio",  32'(perf_mmio),  32'd0);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk_ctrl("rstwait.run", 2'b00, 5'b11111, 1'b0, 1'b0);
        tick();
        #1;
        chk_ctrl("rstwait.run2", 2'b00, 5'b11111, 1'b0, 1'b0);

        // Fresh access after reset: full two-cycle freeze
        ex_mem_mmio = 1'b1;
        #1;
        chk_ctrl("post_rst.c0", 2'b00, 5'b00000, 1'b0, 1'b0);
        tick();
        ex_mem_mmio = 1'b0;
        #1;
        chk_ctrl("post_rst.c1", 2'b00, 5'b00000, 1'b0, 1'b0);
        tick();
        #1;
        chk_ctrl("post_rst.release", 2'b00, 5'b11111, 1'b0, 1'b0);
        tick();
        #1;
        chk_ctrl("post_rst.idle", 2'b00, 5'b11111, 1'b0, 1'b0);
        check("post_rst.perf_mmio",  32'(perf_mmio),  PERF_ON ? 32'd2 : 32'd0);
        check("post_rst.perf_stall", 32'(perf_stall), 32'd0);
        check("post_rst.perf_flush", 32'(perf_flush), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
